// File: rtl/vga_sync_if.sv
// Signals between vga_sync, the graphics block (pixel position, colour) and the VGA connector.
interface vga_sync_if;
  logic [2:0] graph_rgb;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       p_tick;
  logic       frame_end;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;

  modport master (
    input  graph_rgb,
    output pix_x, pix_y, video_on, p_tick, frame_end, hsync, vsync, rgb
  );

  modport slave (
    output graph_rgb,
    input  pix_x, pix_y, video_on, p_tick, frame_end, hsync, vsync, rgb
  );
endinterface

// File: rtl/vga_sync.sv
// VGA 640x480@60 timing generator; VGA_SYNC_ALIGN_EN delays hsync/vsync one pixel to line up with rgb.
// Latency: rgb is one pixel period behind pix_x/pix_y; free-running, no backpressure.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic        clk,
  input logic        reset_n,
  vga_sync_if.master vif
);
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div;
  logic [9:0]       h;
  logic [9:0]       v;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             p_tick;
  logic             h_end;
  logic             v_end;
  logic             video_on;
  logic             hsync_q;
  logic             vsync_q;
  logic [2:0]       rgb_q;

  assign p_tick   = (div == DIV_W'(CLK_DIV - 1));
  assign h_end    = (h == 10'(H_TOTAL - 1));
  assign v_end    = (v == 10'(V_TOTAL - 1));
  assign video_on = (h < 10'(H_DISPLAY)) && (v < 10'(V_DISPLAY));

  always_comb begin
    h_next = h;
    v_next = v;
    if (p_tick) begin
      h_next = h_end ? 10'd0 : h + 10'd1;
      if (h_end) begin
        v_next = v_end ? 10'd0 : v + 10'd1;
      end
    end
  end

  // Syncs decode the next-state counts so they switch on the same edge as h/v.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div     <= '0;
      h       <= 10'd0;
      v       <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      div     <= p_tick ? '0 : div + DIV_W'(1);
      h       <= h_next;
      v       <= v_next;
      hsync_q <= !((h_next >= 10'(HS_START)) && (h_next <= 10'(HS_END)));
      vsync_q <= !((v_next >= 10'(VS_START)) && (v_next <= 10'(VS_END)));
      if (p_tick) begin
        rgb_q <= video_on ? vif.graph_rgb : 3'b000;
      end
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hsync_d;
  logic vsync_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
    end else if (p_tick) begin
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign vif.hsync = hsync_d;
  assign vif.vsync = vsync_d;
`else
  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
`endif

  assign vif.pix_x     = h;
  assign vif.pix_y     = v;
  assign vif.video_on  = video_on;
  assign vif.p_tick    = p_tick;
  assign vif.frame_end = p_tick && h_end && v_end;
  assign vif.rgb       = rgb_q;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a shrunken-timing instance for frame/blanking/reset scenarios, a default one for a full line.
module tb_vga_sync;
  localparam int SCD = 4;
  localparam int SHD = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int SVD = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHD + SHF + SHS + SHB;
  localparam int SVT = SVD + SVF + SVS + SVB;
  localparam int HS0 = SHD + SHF, HS1 = SHD + SHF + SHS - 1;
  localparam int VS0 = SVD + SVF, VS1 = SVD + SVF + SVS - 1;
`ifdef VGA_SYNC_ALIGN_EN
  localparam int AL = 1;
`else
  localparam int AL = 0;
`endif

  logic        clk;
  logic        reset_n;
  int          total;
  int          bad;
  int unsigned cyc;
  logic [2:0]  exp_q[$];

  vga_sync_if s_if();
  vga_sync_if b_if();

  vga_sync #(
    .CLK_DIV(SCD), .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (.clk(clk), .reset_n(reset_n), .vif(s_if));

  vga_sync u_big (.clk(clk), .reset_n(reset_n), .vif(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_tick_s(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      ok = (s_if.p_tick === 1'b1);
    end
  endtask

  task automatic wait_tick_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      ok = (b_if.p_tick === 1'b1);
    end
  endtask

  // Leaves the bench on the negedge of the small instance's frame_end tick.
  task automatic sync_frame(output bit found);
    bit ok;
    found = 1'b0;
    for (int i = 0; i < SHT * SVT + 4 && !found; i++) begin
      wait_tick_s(ok);
      if (!ok) begin
        total++; bad++; $display("FAIL sync_tick_timeout got=none exp=p_tick");
        return;
      end
      found = (s_if.frame_end === 1'b1);
    end
    if (!found) begin
      total++; bad++; $display("FAIL sync_frame_end got=none exp=frame_end");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_if.graph_rgb = 3'b101;
    b_if.graph_rgb = 3'b011;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (s_if.p_tick !== 1'b0) begin bad++; $display("FAIL reset_p_tick got=%0b exp=0", s_if.p_tick); end
    total++; if (s_if.frame_end !== 1'b0) begin bad++; $display("FAIL reset_frame_end got=%0b exp=0", s_if.frame_end); end
    total++; if (s_if.hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%0b exp=1", s_if.hsync); end
    total++; if (s_if.vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%0b exp=1", s_if.vsync); end
    total++; if (s_if.rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb got=%0b exp=000", s_if.rgb); end
    total++; if (s_if.pix_x !== 10'd0) begin bad++; $display("FAIL reset_pix_x got=%0d exp=0", s_if.pix_x); end
    total++; if (s_if.pix_y !== 10'd0) begin bad++; $display("FAIL reset_pix_y got=%0d exp=0", s_if.pix_y); end
    total++; if (s_if.video_on !== 1'b1) begin bad++; $display("FAIL reset_video_on got=%0b exp=1", s_if.video_on); end
    total++; if (b_if.hsync !== 1'b1) begin bad++; $display("FAIL reset_big_hsync got=%0b exp=1", b_if.hsync); end
    total++; if (b_if.vsync !== 1'b1) begin bad++; $display("FAIL reset_big_vsync got=%0b exp=1", b_if.vsync); end
    total++; if (b_if.rgb !== 3'b000) begin bad++; $display("FAIL reset_big_rgb got=%0b exp=000", b_if.rgb); end
    total++; if (b_if.pix_x !== 10'd0) begin bad++; $display("FAIL reset_big_pix_x got=%0d exp=0", b_if.pix_x); end
  endtask

  // Release (or re-release) reset on a negedge and check tick placement clock by clock.
  task automatic test_tick_spacing(input string tag);
    logic exp_t;
    reset_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_t = ((c % SCD) == SCD - 1);
      total++; if (s_if.p_tick !== exp_t) begin bad++; $display("FAIL %s_p_tick clk=%0d got=%0b exp=%0b", tag, c, s_if.p_tick, exp_t); end
      total++; if (s_if.pix_x !== 10'(c / SCD)) begin bad++; $display("FAIL %s_pix_x clk=%0d got=%0d exp=%0d", tag, c, s_if.pix_x, c / SCD); end
      total++; if (b_if.p_tick !== exp_t) begin bad++; $display("FAIL %s_big_p_tick clk=%0d got=%0b exp=%0b", tag, c, b_if.p_tick, exp_t); end
      total++; if (s_if.hsync !== 1'b1) begin bad++; $display("FAIL %s_hsync clk=%0d got=%0b exp=1", tag, c, s_if.hsync); end
    end
  endtask

  task automatic test_hsync_line();
    bit ok;
    bit found;
    int lows;
    int first_low;
    int rise;
    found = 1'b0;
    for (int i = 0; i < 900 && !found; i++) begin
      wait_tick_b(ok);
      if (!ok) begin total++; bad++; $display("FAIL line_tick_timeout got=none exp=p_tick"); return; end
      found = (b_if.pix_x === 10'd0);
    end
    if (!found) begin total++; bad++; $display("FAIL line_start got=none exp=pix_x0"); return; end
    lows = 0; first_low = -1; rise = -1;
    for (int x = 0; x < 800; x++) begin
      if (x > 0) begin
        wait_tick_b(ok);
        if (!ok) begin total++; bad++; $display("FAIL line_tick_timeout x=%0d got=none exp=p_tick", x); return; end
      end
      total++; if (b_if.pix_x !== 10'(x)) begin bad++; $display("FAIL line_pix_x got=%0d exp=%0d", b_if.pix_x, x); end
      if (b_if.hsync === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = x;
      end else if (first_low >= 0 && rise < 0) begin
        rise = x;
      end
    end
    total++; if (lows != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", lows); end
    total++; if (first_low != 656 + AL) begin bad++; $display("FAIL hsync_fall_x got=%0d exp=%0d", first_low, 656 + AL); end
    total++; if (rise != 752 + AL) begin bad++; $display("FAIL hsync_rise_x got=%0d exp=%0d", rise, 752 + AL); end
  endtask

  task automatic test_frame();
    bit ok;
    bit found;
    int xm, ym, px, py, sx, sy, fe_cnt;
    int unsigned last_fe;
    logic hs_e, vs_e, vo_e, fe_e;
    sync_frame(found);
    if (!found) return;
    last_fe = cyc; xm = 0; ym = 0; px = SHT - 1; py = SVT - 1; fe_cnt = 0;
    for (int n = 0; n < 2 * SHT * SVT; n++) begin
      wait_tick_s(ok);
      if (!ok) begin total++; bad++; $display("FAIL frame_tick_timeout got=none exp=p_tick"); return; end
      sx = (AL != 0) ? px : xm;
      sy = (AL != 0) ? py : ym;
      hs_e = !(sx >= HS0 && sx <= HS1);
      vs_e = !(sy >= VS0 && sy <= VS1);
      vo_e = (xm < SHD) && (ym < SVD);
      fe_e = (xm == SHT - 1) && (ym == SVT - 1);
      total++; if (s_if.pix_x !== 10'(xm)) begin bad++; $display("FAIL frame_pix_x got=%0d exp=%0d", s_if.pix_x, xm); end
      total++; if (s_if.pix_y !== 10'(ym)) begin bad++; $display("FAIL frame_pix_y got=%0d exp=%0d", s_if.pix_y, ym); end
      total++; if (!(s_if.pix_x <= 10'(SHT - 1) && s_if.pix_y <= 10'(SVT - 1))) begin bad++; $display("FAIL frame_range got=%0d,%0d exp<=%0d,%0d", s_if.pix_x, s_if.pix_y, SHT - 1, SVT - 1); end
      total++; if (s_if.video_on !== vo_e) begin bad++; $display("FAIL frame_video_on x=%0d y=%0d got=%0b exp=%0b", xm, ym, s_if.video_on, vo_e); end
      total++; if (s_if.hsync !== hs_e) begin bad++; $display("FAIL frame_hsync x=%0d y=%0d got=%0b exp=%0b", xm, ym, s_if.hsync, hs_e); end
      total++; if (s_if.vsync !== vs_e) begin bad++; $display("FAIL frame_vsync x=%0d y=%0d got=%0b exp=%0b", xm, ym, s_if.vsync, vs_e); end
      total++; if (s_if.frame_end !== fe_e) begin bad++; $display("FAIL frame_end x=%0d y=%0d got=%0b exp=%0b", xm, ym, s_if.frame_end, fe_e); end
      if (s_if.frame_end === 1'b1) begin
        fe_cnt++;
        total++; if (cyc - last_fe != SHT * SVT * SCD) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fe, SHT * SVT * SCD); end
        last_fe = cyc;
      end
      px = xm; py = ym;
      if (xm == SHT - 1) begin xm = 0; ym = (ym == SVT - 1) ? 0 : ym + 1; end
      else xm = xm + 1;
    end
    total++; if (fe_cnt != 2) begin bad++; $display("FAIL frame_end_count got=%0d exp=2", fe_cnt); end
  endtask

  task automatic test_blanking();
    bit ok;
    bit found;
    int xm, ym;
    logic [2:0] e;
    sync_frame(found);
    if (!found) return;
    exp_q.delete();
    xm = 0; ym = 0;
    for (int n = 0; n < 2 * SHT * SVT; n++) begin
      wait_tick_s(ok);
      if (!ok) begin total++; bad++; $display("FAIL blank_tick_timeout got=none exp=p_tick"); return; end
      s_if.graph_rgb = (n < SHT * SVT) ? 3'b101 : 3'($urandom_range(0, 7));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (s_if.rgb !== e) begin bad++; $display("FAIL blank_rgb x=%0d y=%0d got=%0b exp=%0b", xm, ym, s_if.rgb, e); end
      end
      exp_q.push_back(((xm < SHD) && (ym < SVD)) ? s_if.graph_rgb : 3'b000);
      if (xm == SHT - 1) begin xm = 0; ym = (ym == SVT - 1) ? 0 : ym + 1; end
      else xm = xm + 1;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit found;
    found = 1'b0;
    for (int i = 0; i < SHT * SVT + 4 && !found; i++) begin
      wait_tick_s(ok);
      if (!ok) begin total++; bad++; $display("FAIL midrst_tick_timeout got=none exp=p_tick"); return; end
      found = (s_if.pix_x === 10'(HS0 + 2 - 1)) && (s_if.pix_y === 10'(VS1));
    end
    if (!found) begin total++; bad++; $display("FAIL midrst_position got=none exp=x%0d_y%0d", HS0 + 1, VS1); return; end
    repeat (2) @(negedge clk);
    total++; if (s_if.pix_x !== 10'(HS0 + 2)) begin bad++; $display("FAIL midrst_pre_pix_x got=%0d exp=%0d", s_if.pix_x, HS0 + 2); end
    total++; if (s_if.hsync !== 1'b0) begin bad++; $display("FAIL midrst_pre_hsync got=%0b exp=0", s_if.hsync); end
    total++; if (s_if.vsync !== 1'b0) begin bad++; $display("FAIL midrst_pre_vsync got=%0b exp=0", s_if.vsync); end
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (s_if.pix_x !== 10'd0) begin bad++; $display("FAIL midrst_pix_x got=%0d exp=0", s_if.pix_x); end
    total++; if (s_if.pix_y !== 10'd0) begin bad++; $display("FAIL midrst_pix_y got=%0d exp=0", s_if.pix_y); end
    total++; if (s_if.hsync !== 1'b1) begin bad++; $display("FAIL midrst_hsync got=%0b exp=1", s_if.hsync); end
    total++; if (s_if.vsync !== 1'b1) begin bad++; $display("FAIL midrst_vsync got=%0b exp=1", s_if.vsync); end
    total++; if (s_if.rgb !== 3'b000) begin bad++; $display("FAIL midrst_rgb got=%0b exp=000", s_if.rgb); end
    total++; if (s_if.p_tick !== 1'b0) begin bad++; $display("FAIL midrst_p_tick got=%0b exp=0", s_if.p_tick); end
    test_tick_spacing("restart");
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    test_reset();
    test_tick_spacing("start");
    test_hsync_line();
    test_frame();
    test_blanking();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the VGA path at 640x480 @ 60 Hz. It derives the pixel tick from the system clock and runs the horizontal/vertical scan counters. It drives `pix_x`, `pix_y` and `video_on` to the graphics block, takes its `graph_rgb` back, and drives registered `rgb`, `hsync` and `vsync` to the connector.

## Interface
Parameters:
- `CLK_DIV`, 4 — system clocks per pixel tick (100 MHz → 25 MHz); legal ≥ 2.
- `H_DISPLAY`, 640 — visible pixels per line.
- `H_FRONT`, 16 — horizontal front porch, in pixels.
- `H_SYNC`, 96 — hsync pulse width, in pixels.
- `H_BACK`, 48 — horizontal back porch, in pixels.
- `V_DISPLAY`, 480 — visible lines per frame.
- `V_FRONT`, 10 — vertical front porch, in lines.
- `V_SYNC`, 2 — vsync pulse width, in lines.
- `V_BACK`, 33 — vertical back porch, in lines.

Ports:
- `clk` in 1 — system clock; single clock domain.
- `reset_n` in 1 — synchronous, active-low reset.
- `graph_rgb` in 3 — pixel colour from the graphics block for the current `pix_x`/`pix_y`.
- `pix_x` out 10 — current horizontal count.
- `pix_y` out 10 — current vertical count.
- `video_on` out 1 — high when the current count is in the visible area.
- `p_tick` out 1 — one-`clk` pulse, once per pixel period.
- `frame_end` out 1 — one-`clk` pulse on the tick that wraps the counters to (0,0).
- `hsync` out 1 — horizontal sync, active-low, registered.
- `vsync` out 1 — vertical sync, active-low, registered.
- `rgb` out 3 — registered, blanked colour to the DAC.

## Operation
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both fit in 10 bits.
- Divider `div`:
  - Counts 0..CLK_DIV-1 on every `clk`, then wraps.
  - `p_tick` = (div == CLK_DIV-1), decoded combinationally from the register.
- Horizontal counter `h`:
  - Changes only when `p_tick` is high.
  - At `p_tick`: h = (h == H_TOTAL-1) ? 0 : h+1.
- Vertical counter `v`:
  - Advances only when `p_tick` is high and h == H_TOTAL-1.
  - Then v = (v == V_TOTAL-1) ? 0 : v+1.
- `pix_x` = h and `pix_y` = v, both combinational from the registers.
- `video_on` = (h < H_DISPLAY) && (v < V_DISPLAY), combinational.
- `frame_end` = `p_tick` && h == H_TOTAL-1 && v == V_TOTAL-1.
- Sync outputs are registered from the next-state counts, so they change on the same edge as h/v:
  - `hsync` low while h_next ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656, 751].
  - `vsync` low while v_next ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490, 491].
- `rgb` register:
  - Loads on `p_tick` only.
  - Loaded value is `graph_rgb` if `video_on`, else 3'b000.
  - Out-of-area colour never reaches the connector.
- No handshakes and no backpressure; the block free-runs.

## Timing
- Reset values: div = 0, h = 0, v = 0.
- Reset output values: `p_tick` 0, `frame_end` 0, `hsync` 1, `vsync` 1, `rgb` 3'b000.
- Reset output values (derived): `pix_x` 0, `pix_y` 0, `video_on` 1 (pixel (0,0) is visible).
- Start-up: the first `p_tick` is asserted CLK_DIV-1 clocks after the first edge with `reset_n` high.
- `p_tick` period is exactly CLK_DIV clocks.
- Line period is H_TOTAL ticks (3200 clk); frame period is H_TOTAL·V_TOTAL·CLK_DIV clk (1,680,000).
- Latency: `rgb` reflects the (x,y) that was current one pixel period earlier.
- `hsync` width: 96 ticks. `vsync` width: 2 lines (1600 ticks).
- Simultaneous events:
  - h wrap and v wrap on the same tick: both counters go to 0 on that edge.
  - `frame_end` is high on that tick only.
- Reset mid-operation:
  - On the next `clk` edge every register returns to its reset value, whatever the state of div, h or v.
  - No partial line or frame is completed.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1.

## Configuration
- Macro: `VGA_SYNC_ALIGN_EN`.
- Defined:
  - `hsync` and `vsync` pass through an extra register stage that loads on `p_tick`.
  - This delays them by one pixel period so they are aligned with `rgb`.
  - Reset value of the extra stage is 1.
  - hsync falls on the tick after h becomes 656.
- Undefined:
  - `hsync`/`vsync` are timed exactly as in Operation.
  - `rgb` lags the syncs by one pixel period.

## Test plan
- Reset and tick spacing: hold `reset_n` = 0 for 5 clk, then release.
  - Outputs show the reset values listed in Timing.
  - First `p_tick` at clk 3 after release, then every 4 clk.
- hsync: run one line.
  - `hsync` = 0 for exactly 96 ticks.
  - The first low tick coincides with `pix_x` = 656; high again at `pix_x` = 752.
- Frame: run 2 frames.
  - `vsync` low only for `pix_y` ∈ {490, 491}.
  - `frame_end` pulses exactly every 1,680,000 clk.
  - `pix_x`/`pix_y` never exceed 799/524.
- Blanking: drive `graph_rgb` = 3'b101 constantly.
  - `rgb` = 3'b101 one tick after each visible pixel.
  - `rgb` = 3'b000 after each pixel with `pix_x` ≥ 640 or `pix_y` ≥ 480.
- Mid-frame reset: assert `reset_n` = 0 for one clk at `pix_x` = 700, `pix_y` = 491.
  - Next edge: h = v = 0, `hsync` = `vsync` = 1, `rgb` = 0.
  - Timing restarts as in the reset scenario.
- With `VGA_SYNC_ALIGN_EN` defined: `hsync` falls one tick later than the undefined build, at `pix_x` = 657, and stays low for 96 ticks.
